icache_line_fill: RTL and testbench

Cache-line fill engine that sits directly upstream of the pipelined Wishbone shift RAM. On a cache miss it accepts one line address and issues `WORDS_PER_LINE` back-to-back pipelined reads. It places each returning word by the RAM's echoed tag, then presents the assembled line to the cache. It never writes.

---
 rtl/icache_pkg.sv | 32 +++
 rtl/icache_line_fill.sv | 199 +++++++++++++++++++
 tb/tb_icache_line_fill.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache line-fill engine.
package icache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fill_state_e;

   // Widest line offset any configuration may need; the engine casts down to OFF_W.
   localparam int LINE_OFF_MAX_W = 16;

   typedef logic [LINE_OFF_MAX_W-1:0] line_off_t;

   function automatic int off_w(input int words);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < words) w = i + 1;
      end
      return w;
   endfunction

   function automatic line_off_t wrap_off(input line_off_t start, input line_off_t cnt,
                                          input int words);
      line_off_t sum;
      sum = start + cnt;
      return sum & line_off_t'(words - 1);
   endfunction

endpackage

// File: rtl/icache_line_fill.sv
// Cache-line fill engine: issues one line of pipelined Wishbone reads and places words by echoed tag.
// Define ICACHE_CRITICAL_WORD_FIRST_EN to start at the missing word and drive crit_valid_o/crit_data_o.
module icache_line_fill
   import icache_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int WORD_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 3,
   parameter int WORDS_PER_LINE  = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 req_valid_i,
   output logic                                 req_ready_o,
   input  logic [ADDR_WIDTH-1:0]                req_addr_i,
   output logic                                 fill_valid_o,
   input  logic                                 fill_ready_i,
   output logic [ADDR_WIDTH-1:0]                fill_base_o,
   output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] fill_line_o,
   output logic                                 fill_err_o,
   output logic                                 crit_valid_o,
   output logic [DATA_WIDTH-1:0]                crit_data_o,
   output logic                                 wb_cyc_o,
   output logic                                 wb_stb_o,
   output logic                                 wb_we_o,
   output logic [ADDR_WIDTH-1:0]                wb_adr_o,
   output logic [DATA_WIDTH-1:0]                wb_dat_o,
   output logic [DATA_WIDTH/WORD_WIDTH-1:0]     wb_sel_o,
   input  logic [DATA_WIDTH-1:0]                wb_dat_i,
   input  logic [ADDR_WIDTH-1:0]                wb_tag_i,
   input  logic                                 wb_ack_i,
   input  logic                                 wb_stall_i
);

   localparam int                    OFF_W    = off_w(WORDS_PER_LINE);
   localparam int                    CNT_W    = off_w(MAX_OUTSTANDING + 1);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(WORDS_PER_LINE - 1);
   localparam logic [OFF_W-1:0]      LAST_CNT = OFF_W'(WORDS_PER_LINE - 1);
   localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(MAX_OUTSTANDING);

   fill_state_e                          r_state;
   logic                                 r_req_ready;
   logic                                 r_cyc;
   logic                                 r_fill_valid;
   logic                                 r_err;
   logic [ADDR_WIDTH-1:0]                r_base;
   logic [OFF_W-1:0]                     r_start;
   logic [OFF_W-1:0]                     r_issue_cnt;
   logic [CNT_W-1:0]                     r_outstanding;
   logic [WORDS_PER_LINE-1:0]            r_valid;
   logic [WORDS_PER_LINE-1:0]            r_issued;
   logic [DATA_WIDTH*WORDS_PER_LINE-1:0] r_line;

   logic [OFF_W-1:0]                     w_req_start;
   logic [OFF_W-1:0]                     w_issue_off;
   logic [OFF_W-1:0]                     w_ack_off;
   logic                                 w_tag_hit;
   logic                                 w_ack_ok;
   logic                                 w_ack_bad;
   logic                                 w_stb;
   logic                                 w_issue;
   logic                                 w_last_issue;
   logic                                 w_all_valid;
   logic [WORDS_PER_LINE-1:0]            w_ack_hot;
   logic [WORDS_PER_LINE-1:0]            w_issue_hot;
   logic [WORDS_PER_LINE-1:0]            w_valid_next;
   logic [CNT_W-1:0]                     w_outstanding_next;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   assign w_req_start = req_addr_i[OFF_W-1:0];
`else
   assign w_req_start = '0;
`endif

   assign w_issue_off = OFF_W'(wrap_off(line_off_t'(r_start), line_off_t'(r_issue_cnt),
                                        WORDS_PER_LINE));

   // An ack is ours only if it lands in this line on a slot that is in flight and not yet filled.
   assign w_ack_off    = wb_tag_i[OFF_W-1:0];
   assign w_tag_hit    = (wb_tag_i & ~OFF_MASK) == r_base;
   assign w_ack_ok     = wb_ack_i && r_cyc && w_tag_hit && r_issued[w_ack_off] && !r_valid[w_ack_off];
   assign w_ack_bad    = wb_ack_i && r_cyc && !w_ack_ok;

   assign w_stb        = (r_state == ST_ISSUE) && !((r_outstanding == CNT_FULL) && !w_ack_ok);
   assign w_issue      = w_stb && !wb_stall_i;
   assign w_last_issue = w_issue && (r_issue_cnt == LAST_CNT);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_ack_hot                = '0;
      w_issue_hot              = '0;
      w_ack_hot[w_ack_off]     = w_ack_ok;
      w_issue_hot[w_issue_off] = w_issue;
   end

   assign w_valid_next = r_valid | w_ack_hot;
   assign w_all_valid  = &w_valid_next;

   always_comb begin
      w_outstanding_next = r_outstanding;
      if (w_issue && !w_ack_ok)      w_outstanding_next = r_outstanding + CNT_W'(1);
      else if (!w_issue && w_ack_ok) w_outstanding_next = r_outstanding - CNT_W'(1);
   end

   // NOTE: the line buffer is reset as well, so fill_line_o reads zero after reset or an aborted fill.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= ST_IDLE;
         r_req_ready   <= 1'b1;
         r_cyc         <= 1'b0;
         r_fill_valid  <= 1'b0;
         r_err         <= 1'b0;
         r_base        <= '0;
         r_start       <= '0;
         r_issue_cnt   <= '0;
         r_outstanding <= '0;
         r_valid       <= '0;
         r_issued      <= '0;
         r_line        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  r_base        <= req_addr_i & ~OFF_MASK;
                  r_start       <= w_req_start;
                  r_issue_cnt   <= '0;
                  r_outstanding <= '0;
                  r_valid       <= '0;
                  r_issued      <= '0;
                  r_err         <= 1'b0;
                  r_req_ready   <= 1'b0;
                  r_cyc         <= 1'b1;
                  r_state       <= ST_ISSUE;
               end
            end
            ST_ISSUE, ST_DRAIN: begin
               if (w_issue) r_issue_cnt <= r_issue_cnt + OFF_W'(1);
               r_issued      <= r_issued | w_issue_hot;
               r_valid       <= w_valid_next;
               r_outstanding <= w_outstanding_next;
               if (w_ack_bad) r_err <= 1'b1;
               for (int k = 0; k < WORDS_PER_LINE; k++) begin
                  if (w_ack_hot[k]) r_line[k*DATA_WIDTH +: DATA_WIDTH] <= wb_dat_i;
               end
               if (w_all_valid) begin
                  r_cyc        <= 1'b0;
                  r_fill_valid <= 1'b1;
                  r_state      <= ST_DONE;
               end else if (w_last_issue) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DONE: begin
               if (fill_ready_i) begin
                  r_fill_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   logic                  r_crit_valid;
   logic [DATA_WIDTH-1:0] r_crit_data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_crit_valid <= 1'b0;
         r_crit_data  <= '0;
      end else begin
         r_crit_valid <= w_ack_ok && (w_ack_off == r_start);
         if (w_ack_ok && (w_ack_off == r_start)) r_crit_data <= wb_dat_i;
      end
   end

   assign crit_valid_o = r_crit_valid;
   assign crit_data_o  = r_crit_data;
`else
   assign crit_valid_o = 1'b0;
   assign crit_data_o  = '0;
`endif

   assign req_ready_o  = r_req_ready;
   assign fill_valid_o = r_fill_valid;
   assign fill_base_o  = r_base;
   assign fill_line_o  = r_line;
   assign fill_err_o   = r_err;
   assign wb_cyc_o     = r_cyc;
   assign wb_stb_o     = w_stb;
   assign wb_we_o      = 1'b0;
   assign wb_adr_o     = r_base | ADDR_WIDTH'(w_issue_off);
   assign wb_dat_o     = '0;
   assign wb_sel_o     = '1;

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: two instances (MAX_OUTSTANDING 4 and 1) on a tagged pipelined RAM model.
module tb_icache_line_fill;

   localparam int DW  = 32;
   localparam int AW  = 3;
   localparam int WPL = 4;
   localparam int LW  = DW * WPL;
   localparam int SW  = DW / 8;
   localparam int LAT = 4;   // edges from issue sample to ack capture

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          req_valid [2];
   logic          req_ready [2];
   logic [AW-1:0] req_addr  [2];
   logic          fill_valid[2];
   logic          fill_ready[2];
   logic [AW-1:0] fill_base [2];
   logic [LW-1:0] fill_line [2];
   logic          fill_err  [2];
   logic          crit_valid[2];
   logic [DW-1:0] crit_data [2];
   logic          wb_cyc    [2];
   logic          wb_stb    [2];
   logic          wb_we     [2];
   logic [AW-1:0] wb_adr    [2];
   logic [DW-1:0] wb_dat_o  [2];
   logic [SW-1:0] wb_sel    [2];
   logic [DW-1:0] wb_dat_i  [2];
   logic [AW-1:0] wb_tag    [2];
   logic          wb_ack    [2];
   logic          stall     [2];
   logic          inj_ack   [2];
   logic [AW-1:0] inj_tag   [2];
   logic [DW-1:0] inj_dat;

   logic [LAT-1:0] pv[2];
   logic [AW-1:0]  pa[2][LAT];
   logic [AW-1:0]  iss_log[2][64];
   int             iss_n[2] = '{0, 0};

   int n_cmp = 0;
   int n_mis = 0;

   function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
      return {8'hA5, 5'd0, a, 8'h3C, 5'h1F, ~a};
   endfunction

   function automatic logic [LW-1:0] exp_line(input logic [AW-1:0] base);
      logic [LW-1:0] l;
      l = '0;
      for (int k = 0; k < WPL; k++) l[k*DW +: DW] = ram_word(base | AW'(k));
      return l;
   endfunction

   function automatic logic [AW-1:0] exp_adr(input logic [AW-1:0] addr, input int k);
      int start;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      start = int'(addr) % WPL;
`else
      start = 0;
`endif
      return (addr & ~AW'(WPL - 1)) | AW'((start + k) % WPL);
   endfunction

   icache_line_fill #(.MAX_OUTSTANDING(4)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
      .fill_valid_o(fill_valid[0]), .fill_ready_i(fill_ready[0]), .fill_base_o(fill_base[0]),
      .fill_line_o(fill_line[0]), .fill_err_o(fill_err[0]),
      .crit_valid_o(crit_valid[0]), .crit_data_o(crit_data[0]),
      .wb_cyc_o(wb_cyc[0]), .wb_stb_o(wb_stb[0]), .wb_we_o(wb_we[0]), .wb_adr_o(wb_adr[0]),
      .wb_dat_o(wb_dat_o[0]), .wb_sel_o(wb_sel[0]),
      .wb_dat_i(wb_dat_i[0]), .wb_tag_i(wb_tag[0]), .wb_ack_i(wb_ack[0]), .wb_stall_i(stall[0])
   );

   icache_line_fill #(.MAX_OUTSTANDING(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
      .fill_valid_o(fill_valid[1]), .fill_ready_i(fill_ready[1]), .fill_base_o(fill_base[1]),
      .fill_line_o(fill_line[1]), .fill_err_o(fill_err[1]),
      .crit_valid_o(crit_valid[1]), .crit_data_o(crit_data[1]),
      .wb_cyc_o(wb_cyc[1]), .wb_stb_o(wb_stb[1]), .wb_we_o(wb_we[1]), .wb_adr_o(wb_adr[1]),
      .wb_dat_o(wb_dat_o[1]), .wb_sel_o(wb_sel[1]),
      .wb_dat_i(wb_dat_i[1]), .wb_tag_i(wb_tag[1]), .wb_ack_i(wb_ack[1]), .wb_stall_i(stall[1])
   );

   // Tagged RAM model: shares the reset, echoes the read address as the tag LAT edges later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) pv[d] <= '0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            pv[d] <= {pv[d][LAT-2:0], wb_cyc[d] && wb_stb[d] && !stall[d]};
            for (int s = LAT - 1; s > 0; s--) pa[d][s] <= pa[d][s-1];
            pa[d][0] <= wb_adr[d];
            if (wb_cyc[d] && wb_stb[d] && !stall[d]) begin
               iss_log[d][iss_n[d] % 64] <= wb_adr[d];
               iss_n[d] <= iss_n[d] + 1;
            end
         end
      end
   end

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         wb_ack[d]   = pv[d][LAT-1] | inj_ack[d];
         wb_tag[d]   = inj_ack[d] ? inj_tag[d] : pa[d][LAT-1];
         wb_dat_i[d] = inj_ack[d] ? inj_dat : ram_word(pa[d][LAT-1]);
      end
   end

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_fill(input int d, input logic [AW-1:0] addr, input int stall_at,
                           input int stall_len, input int inj_at, input int exp_cyc,
                           input logic exp_err, input string name);
      int            n;
      int            start_n;
      int            crit_n;
      logic [DW-1:0] crit_d;
      logic [AW-1:0] base;
      base    = addr & ~AW'(WPL - 1);
      start_n = iss_n[d];
      crit_n  = 0;
      crit_d  = '0;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_addr[d]  = addr;
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      check($sformatf("%s_accept", name), LW'(req_ready[d]), LW'(0));
      n = 0;
      while (n < 200 && !fill_valid[d]) begin
         n++;
         stall[d]   = (n > stall_at) && (n <= stall_at + stall_len);
         inj_ack[d] = (n == inj_at);
         @(posedge clk);
         #1;
         if (crit_valid[d]) begin
            crit_n++;
            crit_d = crit_data[d];
         end
      end
      stall[d]   = 1'b0;
      inj_ack[d] = 1'b0;
      check($sformatf("%s_cycles", name), LW'(n), LW'(exp_cyc));
      check($sformatf("%s_issues", name), LW'(iss_n[d] - start_n), LW'(WPL));
      for (int k = 0; k < WPL; k++)
         check($sformatf("%s_adr%0d", name, k), LW'(iss_log[d][(start_n + k) % 64]),
               LW'(exp_adr(addr, k)));
      check($sformatf("%s_base", name), LW'(fill_base[d]), LW'(base));
      check($sformatf("%s_line", name), fill_line[d], exp_line(base));
      check($sformatf("%s_err", name), LW'(fill_err[d]), LW'(exp_err));
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      check($sformatf("%s_crit_cnt", name), LW'(crit_n), LW'(1));
      check($sformatf("%s_crit_dat", name), LW'(crit_d), LW'(ram_word(addr)));
`else
      check($sformatf("%s_crit_cnt", name), LW'(crit_n), LW'(0));
`endif
   endtask

   task automatic finish_fill(input int d, input string name);
      @(negedge clk);
      fill_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      fill_ready[d] = 1'b0;
      check($sformatf("%s_valid_drop", name), LW'(fill_valid[d]), LW'(0));
      check($sformatf("%s_ready_back", name), LW'(req_ready[d]), LW'(1));
   endtask

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         req_valid[d]  = 1'b0;
         req_addr[d]   = '0;
         fill_ready[d] = 1'b0;
         stall[d]      = 1'b0;
         inj_ack[d]    = 1'b0;
         inj_tag[d]    = '0;
      end
      inj_dat = 32'hDEAD_BEEF;

      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready",  LW'(req_ready[0]),  LW'(1));
      check("rst_fill_valid", LW'(fill_valid[0]), LW'(0));
      check("rst_cyc",        LW'(wb_cyc[0]),     LW'(0));
      check("rst_stb",        LW'(wb_stb[0]),     LW'(0));
      check("rst_we",         LW'(wb_we[0]),      LW'(0));
      check("rst_sel",        LW'(wb_sel[0]),     LW'(4'hF));
      check("rst_dat_o",      LW'(wb_dat_o[0]),   LW'(0));
      check("rst_adr",        LW'(wb_adr[0]),     LW'(0));
      check("rst_line",       fill_line[0],       LW'(0));
      check("rst_err",        LW'(fill_err[0]),   LW'(0));
      check("rst_crit",       LW'(crit_valid[0]), LW'(0));
      check("rst_ready1",     LW'(req_ready[1]),  LW'(1));
      @(negedge clk);
      rst_n = 1'b1;

      run_fill(0, 3'd5, 0, 0, 0, 8, 1'b0, "nostall");
      finish_fill(0, "nostall");

      run_fill(0, 3'd3, 2, 3, 0, 11, 1'b0, "stall");
      finish_fill(0, "stall");

      run_fill(1, 3'd6, 0, 0, 0, 17, 1'b0, "max1");
      finish_fill(1, "max1");

      inj_tag[0] = 3'd0;
      run_fill(0, 3'd5, 0, 0, 2, 8, 1'b1, "stray");
      finish_fill(0, "stray");

      run_fill(0, 3'd1, 0, 0, 0, 8, 1'b0, "hold");
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_addr[0]  = 3'd6;
      repeat (10) @(posedge clk);
      #1;
      check("hold_valid", LW'(fill_valid[0]), LW'(1));
      check("hold_line",  fill_line[0],       exp_line(3'd0));
      check("hold_base",  LW'(fill_base[0]),  LW'(0));
      check("hold_ready", LW'(req_ready[0]),  LW'(0));
      @(negedge clk);
      fill_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      fill_ready[0] = 1'b0;
      req_valid[0]  = 1'b0;
      check("hold_release_ready", LW'(req_ready[0]),  LW'(1));
      check("hold_release_valid", LW'(fill_valid[0]), LW'(0));
      @(posedge clk);
      #1;
      check("hold_no_accept_cyc", LW'(wb_cyc[0]), LW'(0));

      @(negedge clk);
      req_valid[0] = 1'b1;
      req_addr[0]  = 3'd2;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      n = 0;
      while (n < 50 && !(wb_cyc[0] && !wb_stb[0])) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_reached", LW'(wb_cyc[0] && !wb_stb[0]), LW'(1));
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_cyc",   LW'(wb_cyc[0]),     LW'(0));
      check("arst_stb",   LW'(wb_stb[0]),     LW'(0));
      check("arst_ready", LW'(req_ready[0]),  LW'(1));
      check("arst_valid", LW'(fill_valid[0]), LW'(0));
      check("arst_line",  fill_line[0],       LW'(0));
      check("arst_adr",   LW'(wb_adr[0]),     LW'(0));
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      run_fill(0, 3'd3, 0, 0, 0, 8, 1'b0, "after_rst");
      finish_fill(0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
